// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter that shares one i2c_master between NUM_CLIENTS requesters.
// The winner's descriptor is latched at grant, a single start pulse is issued,
// and the master's byte strobes are routed to the owner until the master drops busy.
// Optional feature macro: I2C_ARB_TIMEOUT_EN adds an ACTIVE-state watchdog that
// pulses the master's abort bit after TIMEOUT_CYCLES and reports the transfer as NACKed.
module i2c_master_arbiter #(
    parameter int NUM_CLIENTS    = 4,
    parameter int WAIT_BUSY_MAX  = 64,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [NUM_CLIENTS-1:0]    i_req,
    input  logic [NUM_CLIENTS*10-1:0] i_slave_addr,
    input  logic [NUM_CLIENTS*8-1:0]  i_byte_cnt,
    input  logic [NUM_CLIENTS-1:0]    i_read,
    input  logic [NUM_CLIENTS*8-1:0]  i_tx_data,
    output logic [NUM_CLIENTS-1:0]    o_grant,
    output logic [NUM_CLIENTS-1:0]    o_tx_data_needed,
    output logic [NUM_CLIENTS-1:0]    o_rx_data_valid,
    output logic [7:0]                o_rx_data,
    output logic [NUM_CLIENTS-1:0]    o_done,
    output logic [NUM_CLIENTS-1:0]    o_nack,
    output logic [9:0]                m_slave_addr,
    output logic [7:0]                m_byte_cnt,
    output logic [7:0]                m_tx_data,
    output logic [3:0]                m_control_reg,
    output logic [3:0]                m_mode_reg,
    input  logic                      m_tx_data_needed,
    input  logic                      m_rx_data_valid,
    input  logic [7:0]                m_rx_data,
    input  logic [4:0]                m_status_reg
);

    localparam int IDX_W = $clog2(NUM_CLIENTS);
    localparam int WB_W  = $clog2(WAIT_BUSY_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_ACTIVE,
        S_ABORT,
        S_DONE
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] rr_next;
    logic [WB_W-1:0]  wait_cnt;
    logic             nack_flag;
    logic             start_pulse;
    logic             abort_pulse;
    logic             mode_read;
    logic             status_err;
    logic             unused_bits;

    // First requester at or after ptr, wrapping; the rotated copy puts req[ptr] at bit 0.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_CLIENTS-1:0] req,
                                                 input logic [IDX_W-1:0] ptr);
        logic [2*NUM_CLIENTS-1:0] dbl;
        logic [NUM_CLIENTS-1:0]   rot;
        logic [IDX_W:0]           sum;
        logic [IDX_W-1:0]         sel;
        dbl = {req, req} >> ptr;
        rot = dbl[NUM_CLIENTS-1:0];
        sel = ptr;
        for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
            sum = {1'b0, ptr} + (IDX_W + 1)'(i);
            if (sum >= (IDX_W + 1)'(NUM_CLIENTS)) begin
                sum = sum - (IDX_W + 1)'(NUM_CLIENTS);
            end
            if (rot[i]) begin
                sel = sum[IDX_W-1:0];
            end
        end
        return sel;
    endfunction

    assign winner     = rr_pick(i_req, rr_ptr);
    assign rr_next    = (owner == IDX_W'(NUM_CLIENTS - 1)) ? '0 : owner + 1'b1;
    assign status_err = m_status_reg[1] | m_status_reg[2];

    // Byte-level handshakes pass straight through so the owner can answer in the same cycle.
    assign m_tx_data        = (|o_grant) ? i_tx_data[owner*8 +: 8] : 8'h00;
    assign o_tx_data_needed = (state == S_ACTIVE && m_tx_data_needed) ? o_grant : '0;
    assign m_control_reg    = {start_pulse, abort_pulse, 2'b00};
    assign m_mode_reg       = {3'b000, mode_read};

    // Status bits 4:3 carry nothing the arbiter needs.
    assign unused_bits = ^{m_status_reg[4:3], (TIMEOUT_CYCLES != 0)};

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt;
`else
    assign abort_pulse = 1'b0;
`endif

    // Arbitration FSM; every output it owns is registered and pulses default low.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state           <= S_IDLE;
            owner           <= '0;
            rr_ptr          <= '0;
            wait_cnt        <= '0;
            nack_flag       <= 1'b0;
            start_pulse     <= 1'b0;
            mode_read       <= 1'b0;
            o_grant         <= '0;
            o_rx_data_valid <= '0;
            o_rx_data       <= 8'h00;
            o_done          <= '0;
            o_nack          <= '0;
            m_slave_addr    <= 10'h000;
            m_byte_cnt      <= 8'h00;
`ifdef I2C_ARB_TIMEOUT_EN
            abort_pulse     <= 1'b0;
            to_cnt          <= '0;
`endif
        end else begin
            start_pulse     <= 1'b0;
            o_done          <= '0;
            o_nack          <= '0;
            o_rx_data_valid <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
            abort_pulse     <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (|i_req) begin
                        owner        <= winner;
                        o_grant      <= NUM_CLIENTS'(1) << winner;
                        m_slave_addr <= i_slave_addr[winner*10 +: 10];
                        m_byte_cnt   <= i_byte_cnt[winner*8 +: 8];
                        mode_read    <= i_read[winner];
                        nack_flag    <= 1'b0;
                        // A zero-length descriptor never reaches the master.
                        start_pulse  <= (i_byte_cnt[winner*8 +: 8] != 8'h00);
                        state        <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    wait_cnt <= '0;
                    if (m_byte_cnt == 8'h00) begin
                        o_done <= o_grant;
                        o_nack <= o_grant;
                        state  <= S_DONE;
                    end else begin
                        state  <= S_WAIT_BUSY;
                    end
                end
                S_WAIT_BUSY: begin
                    if (m_status_reg[0]) begin
`ifdef I2C_ARB_TIMEOUT_EN
                        to_cnt <= '0;
`endif
                        state  <= S_ACTIVE;
                    end else if (wait_cnt == WB_W'(WAIT_BUSY_MAX - 1)) begin
                        o_done <= o_grant;
                        o_nack <= o_grant;
                        state  <= S_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_ACTIVE: begin
                    if (m_rx_data_valid) begin
                        o_rx_data_valid <= o_grant;
                        o_rx_data       <= m_rx_data;
                    end
                    if (status_err) begin
                        nack_flag <= 1'b1;
                    end
                    if (!m_status_reg[0]) begin
                        o_done <= o_grant;
                        o_nack <= (nack_flag || status_err) ? o_grant : '0;
                        state  <= S_DONE;
                    end
`ifdef I2C_ARB_TIMEOUT_EN
                    else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        abort_pulse <= 1'b1;
                        state       <= S_ABORT;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end
`ifdef I2C_ARB_TIMEOUT_EN
                S_ABORT: begin
                    // The aborted transfer always reports NACK once the master goes idle.
                    if (!m_status_reg[0]) begin
                        o_done <= o_grant;
                        o_nack <= o_grant;
                        state  <= S_DONE;
                    end
                end
`endif
                S_DONE: begin
                    o_grant <= '0;
                    rr_ptr  <= rr_next;
                    state   <= S_IDLE;
                end
                default: begin
                    o_grant <= '0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Directed bench for i2c_master_arbiter: the bench plays the i2c_master side
// (busy/NACK status and byte strobes) and the four clients.
module tb_i2c_master_arbiter;

    localparam int N   = 4;
    localparam int WBM = 8;
    localparam int TO  = 40;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  i_req;
    logic [N*10-1:0] i_slave_addr;
    logic [N*8-1:0]  i_byte_cnt;
    logic [N-1:0]  i_read;
    logic [N*8-1:0]  i_tx_data;
    logic [N-1:0]  o_grant, o_tx_data_needed, o_rx_data_valid, o_done, o_nack;
    logic [7:0]    o_rx_data;
    logic [9:0]    m_slave_addr;
    logic [7:0]    m_byte_cnt, m_tx_data;
    logic [3:0]    m_control_reg, m_mode_reg;
    logic          m_tx_data_needed, m_rx_data_valid;
    logic [7:0]    m_rx_data;
    logic [4:0]    m_status_reg;

    always #5 clk = ~clk;

    i2c_master_arbiter #(
        .NUM_CLIENTS   (N),
        .WAIT_BUSY_MAX (WBM),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_req            (i_req),
        .i_slave_addr     (i_slave_addr),
        .i_byte_cnt       (i_byte_cnt),
        .i_read           (i_read),
        .i_tx_data        (i_tx_data),
        .o_grant          (o_grant),
        .o_tx_data_needed (o_tx_data_needed),
        .o_rx_data_valid  (o_rx_data_valid),
        .o_rx_data        (o_rx_data),
        .o_done           (o_done),
        .o_nack           (o_nack),
        .m_slave_addr     (m_slave_addr),
        .m_byte_cnt       (m_byte_cnt),
        .m_tx_data        (m_tx_data),
        .m_control_reg    (m_control_reg),
        .m_mode_reg       (m_mode_reg),
        .m_tx_data_needed (m_tx_data_needed),
        .m_rx_data_valid  (m_rx_data_valid),
        .m_rx_data        (m_rx_data),
        .m_status_reg     (m_status_reg)
    );

    typedef struct {
        logic [3:0]  req;
        int          owner;
        logic [9:0]  addr;
        logic [7:0]  cnt;
        logic        rd;
        int          nbytes;
        logic [23:0] bytes;
        logic        nack;
    } vec_t;

    vec_t vecs[10];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Owner gets the given descriptor; every other client gets distinct junk.
    task automatic set_desc(input int owner, input logic [9:0] addr, input logic [7:0] cnt,
                            input logic rd);
        for (int k = 0; k < N; k++) begin
            if (k == owner) begin
                i_slave_addr[k*10 +: 10] = addr;
                i_byte_cnt[k*8 +: 8]     = cnt;
                i_read[k]                = rd;
            end else begin
                i_slave_addr[k*10 +: 10] = 10'h3F0 | 10'(k);
                i_byte_cnt[k*8 +: 8]     = 8'hE0 | 8'(k);
                i_read[k]                = ~rd;
            end
            i_tx_data[k*8 +: 8] = 8'hF0 | 8'(k);
        end
    endtask

    task automatic wait_grant(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (o_grant != '0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("grant_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_vec(input vec_t v);
        logic [N-1:0] onehot;
        logic [7:0]   b;
        bit           ok;
        onehot = N'(1) << v.owner;
        set_desc(v.owner, v.addr, v.cnt, v.rd);
        i_req = v.req;
        wait_grant(ok);
        if (!ok) begin
            i_req = '0;
            return;
        end
        check("grant", 32'(o_grant), 32'(onehot));
        check("start", 32'(m_control_reg), 32'h8);
        check("addr", 32'(m_slave_addr), 32'(v.addr));
        check("cnt", 32'(m_byte_cnt), 32'(v.cnt));
        check("mode", 32'(m_mode_reg), {31'd0, v.rd});
        i_slave_addr[v.owner*10 +: 10] = 10'h3FF;
        m_status_reg = 5'b00001;
        @(negedge clk);
        check("start_len", 32'(m_control_reg), 32'h0);
        i_req[v.owner] = 1'b0;
        @(negedge clk);
        for (int k = 0; k < v.nbytes; k++) begin
            b = v.bytes[8*k +: 8];
            if (!v.rd) begin
                i_tx_data[v.owner*8 +: 8] = b;
                m_tx_data_needed = 1'b1;
                #1;
                check("tx_needed", 32'(o_tx_data_needed), 32'(onehot));
                check("tx_data", 32'(m_tx_data), 32'(b));
                @(negedge clk);
                m_tx_data_needed = 1'b0;
                #1;
                check("tx_needed_len", 32'(o_tx_data_needed), 32'h0);
            end else begin
                m_rx_data = b;
                m_rx_data_valid = 1'b1;
                @(negedge clk);
                m_rx_data_valid = 1'b0;
                check("rx_valid", 32'(o_rx_data_valid), 32'(onehot));
                check("rx_data", 32'(o_rx_data), 32'(b));
                @(negedge clk);
                check("rx_valid_len", 32'(o_rx_data_valid), 32'h0);
            end
        end
        if (v.nack) begin
            m_status_reg = 5'b00011;
            @(negedge clk);
            m_status_reg = 5'b00001;
            @(negedge clk);
        end
        m_status_reg = 5'b00000;
        @(negedge clk);
        check("done", 32'(o_done), 32'(onehot));
        check("nack", 32'(o_nack), v.nack ? 32'(onehot) : 32'h0);
        check("addr_hold", 32'(m_slave_addr), 32'(v.addr));
        i_req = '0;
        @(negedge clk);
        check("done_len", 32'(o_done), 32'h0);
        check("grant_clr", 32'(o_grant), 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        int lat;

        vecs[0] = '{4'b0001, 0, 10'h055, 8'd2, 1'b0, 2, 24'h005703, 1'b0};
        vecs[1] = '{4'b1111, 1, 10'h0A1, 8'd1, 1'b0, 1, 24'h0000C4, 1'b0};
        vecs[2] = '{4'b1111, 2, 10'h0B2, 8'd2, 1'b1, 2, 24'h00BBAA, 1'b0};
        vecs[3] = '{4'b1111, 3, 10'h3C3, 8'd3, 1'b0, 3, 24'h332211, 1'b0};
        vecs[4] = '{4'b1111, 0, 10'h044, 8'd1, 1'b1, 1, 24'h00005A, 1'b0};
        vecs[5] = '{4'b1111, 1, 10'h111, 8'd2, 1'b0, 2, 24'h00EFBE, 1'b0};
        vecs[6] = '{4'b0100, 2, 10'h048, 8'd3, 1'b1, 3, 24'hA3A2A1, 1'b0};
        vecs[7] = '{4'b0010, 1, 10'h022, 8'd1, 1'b0, 0, 24'h000000, 1'b1};
        vecs[8] = '{4'b0011, 0, 10'h070, 8'd1, 1'b0, 1, 24'h000011, 1'b0};
        vecs[9] = '{4'b1001, 3, 10'h07F, 8'd1, 1'b1, 1, 24'h000099, 1'b0};

        rst_n            = 1'b0;
        i_req            = '0;
        i_slave_addr     = '0;
        i_byte_cnt       = '0;
        i_read           = '0;
        i_tx_data        = '0;
        m_tx_data_needed = 1'b0;
        m_rx_data_valid  = 1'b0;
        m_rx_data        = 8'h00;
        m_status_reg     = 5'b00000;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        check("rst_grant", 32'(o_grant), 32'h0);
        check("rst_done", 32'(o_done), 32'h0);
        check("rst_nack", 32'(o_nack), 32'h0);
        check("rst_ctrl", 32'(m_control_reg), 32'h0);
        check("rst_mode", 32'(m_mode_reg), 32'h0);
        check("rst_addr", 32'(m_slave_addr), 32'h0);
        check("rst_txdata", 32'(m_tx_data), 32'h0);
        check("rst_rxvalid", 32'(o_rx_data_valid), 32'h0);

        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i]);
        end

        // Zero-length request: done+nack the cycle after grant, no start pulse
        set_desc(2, 10'h012, 8'd0, 1'b0);
        i_req = 4'b0100;
        wait_grant(ok);
        check("cnt0_grant", 32'(o_grant), 32'h4);
        check("cnt0_no_start", 32'(m_control_reg), 32'h0);
        check("cnt0_early_done", 32'(o_done), 32'h0);
        @(negedge clk);
        check("cnt0_done", 32'(o_done), 32'h4);
        check("cnt0_nack", 32'(o_nack), 32'h4);
        check("cnt0_ctrl", 32'(m_control_reg), 32'h0);
        i_req = '0;
        @(negedge clk);

        // Async reset in ACTIVE, then rr pointer restart at client 0
        set_desc(1, 10'h155, 8'd2, 1'b0);
        i_req = 4'b0010;
        wait_grant(ok);
        check("pre_rst_grant", 32'(o_grant), 32'h2);
        m_status_reg = 5'b00001;
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_grant", 32'(o_grant), 32'h0);
        check("arst_addr", 32'(m_slave_addr), 32'h0);
        check("arst_cnt", 32'(m_byte_cnt), 32'h0);
        check("arst_txdata", 32'(m_tx_data), 32'h0);
        @(negedge clk);
        m_status_reg = 5'b00000;
        rst_n = 1'b1;
        set_desc(0, 10'h0AA, 8'd1, 1'b0);
        i_req = 4'b1111;
        wait_grant(ok);
        check("rr_after_rst", 32'(o_grant), 32'h1);

        // Master never raises busy: give up after WAIT_BUSY_MAX cycles with NACK
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            lat++;
            if (o_done != '0) break;
        end
        check("wb_latency", 32'(lat), 32'(WBM + 1));
        check("wb_done", 32'(o_done), 32'h1);
        check("wb_nack", 32'(o_nack), 32'h1);
        i_req = '0;
        @(negedge clk);

`ifdef I2C_ARB_TIMEOUT_EN
        // Busy stuck high: abort pulse after TIMEOUT_CYCLES in ACTIVE, then NACK
        set_desc(1, 10'h1AB, 8'd4, 1'b0);
        i_req = 4'b0010;
        wait_grant(ok);
        check("to_grant", 32'(o_grant), 32'h2);
        m_status_reg = 5'b00001;
        lat = 0;
        for (int i = 0; i < TO + 20; i++) begin
            @(negedge clk);
            lat++;
            if (m_control_reg[2]) break;
        end
        check("abort_latency", 32'(lat), 32'(TO + 2));
        check("abort_ctrl", 32'(m_control_reg), 32'h4);
        @(negedge clk);
        check("abort_len", 32'(m_control_reg), 32'h0);
        m_status_reg = 5'b00000;
        @(negedge clk);
        check("to_done", 32'(o_done), 32'h2);
        check("to_nack", 32'(o_nack), 32'h2);
        i_req = '0;
        @(negedge clk);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
